// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter and its round-robin picker.
// Pure declarations: no latency, no backpressure.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index width that stays >= 1 even for a 2-entry space.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // (base + offset) mod n, assuming both operands are already below n.
  function automatic int rr_slot(input int base, input int offset, input int n);
    int s;
    s = base + offset;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bundle of the shared-register arbiter: requests, data, grants, register view.
// master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         q;
  logic [IW-1:0]            q_owner;
  logic                     q_valid;
  logic                     locked;

  modport master (
    output req, lock, wdata,
    input  gnt, q, q_owner, q_valid, locked
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, q_owner, q_valid, locked
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the far end back toward ptr so the closest requester is written last.
  always_comb begin
    int slot;
    slot = 0;
    gnt  = '0;
    idx  = '0;
    any  = |req;
    for (int k = N - 1; k >= 0; k--) begin
      slot = rr_slot(int'(ptr), k, N);
      if (req[slot]) begin
        gnt       = '0;
        gnt[slot] = 1'b1;
        idx       = IW'(slot);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter with bounded ownership lock for one shared register.
// Grant is combinational (0 cycles), write lands on the next edge; losers simply see gnt=0.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int               NUM_REQ  = 4,
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               MAX_LOCK = 16
) (
  input logic               clk,
  input logic               rst,
  shared_reg_arbiter_if.slave bus
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = idx_width(MAX_LOCK);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_nxt;
  logic [CW-1:0]    lock_cnt;
  logic [CW-1:0]    lock_cnt_nxt;

  logic [WIDTH-1:0] q_r;
  logic [IW-1:0]    owner_r;
  logic             valid_r;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] gnt_c;
  logic               wr_en;
  logic [IW-1:0]      wr_idx;
  logic [WIDTH-1:0]   wdata_sel;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lock_cnt_nxt = lock_cnt;
    gnt_c        = '0;
    wr_en        = 1'b0;
    wr_idx       = owner_r;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_c   = pick_gnt;
          wr_en   = 1'b1;
          wr_idx  = pick_idx;
          ptr_nxt = IW'(rr_slot(int'(pick_idx), 1, NUM_REQ));
          if (bus.lock[pick_idx]) begin
            state_nxt    = LOCKED;
            lock_cnt_nxt = CW'(1);
          end
        end
      end
      LOCKED: begin
        // Only the owner is visible here; everyone else waits for the cycle after exit.
        if (bus.req[owner_r]) begin
          gnt_c[owner_r] = 1'b1;
          wr_en          = 1'b1;
        end
        lock_cnt_nxt = lock_cnt + 1'b1;
        if (!bus.lock[owner_r] || lock_cnt == CNT_LAST) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
          ptr_nxt      = IW'(rr_slot(int'(owner_r), 1, NUM_REQ));
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_idx == IW'(i)) begin
        wdata_sel = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r     <= RST_VAL;
      owner_r <= '0;
      valid_r <= 1'b0;
    end else if (wr_en) begin
      q_r     <= wdata_sel;
      owner_r <= wr_idx;
      valid_r <= 1'b1;
    end
  end

  // Grant is masked by reset directly so it drops without waiting for an edge.
  assign bus.gnt     = rst ? gnt_c : '0;
  assign bus.q       = q_r;
  assign bus.q_owner = owner_r;
  assign bus.q_valid = valid_r;
  assign bus.locked  = (state == LOCKED);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.gnt));
  a_q_hold:     assert property (@(posedge clk) disable iff (!rst) !(|bus.gnt) |=> $stable(bus.q));

endmodule
